// File: rtl/div_result_stage.sv
// Output stage of the pipelined signed divider: sign-corrects the quotient and
// remainder magnitudes, flags divide-by-zero, and buffers results in a small FIFO.
module div_result_stage #(
    parameter int tamanyo    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RSTa,
    input  logic                          Done,
    input  logic [tamanyo-1:0]            Q,
    input  logic [tamanyo-1:0]            ACCU,
    input  logic [tamanyo-1:0]            M,
    input  logic                          SignNum,
    input  logic                          SignDen,
    input  logic                          Out_Ready,
    input  logic                          Clr_Ovf,
    output logic                          Out_Valid,
    output logic [tamanyo-1:0]            Cociente,
    output logic [tamanyo-1:0]            Resto,
    output logic                          DivZero,
    output logic                          Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [tamanyo-1:0] coc;
        logic [tamanyo-1:0] res;
        logic               dz;
    } entry_t;

    entry_t          mem_q [FIFO_DEPTH];
    entry_t          mem_d [FIFO_DEPTH];
    entry_t          head_q, head_d;
    entry_t          new_entry;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic            pop, push, drop, full;

    // Sign correction; quotient negative when the operand signs differ,
    // remainder follows the numerator. A zero divisor overrides both.
    always_comb begin
        new_entry = '0;
        if (M == '0) begin
            new_entry.coc = '1;
            new_entry.res = '0;
            new_entry.dz  = 1'b1;
        end else begin
            new_entry.coc = (SignNum ^ SignDen) ? (~Q + tamanyo'(1)) : Q;
            new_entry.res = SignNum ? (~ACCU + tamanyo'(1)) : ACCU;
            new_entry.dz  = 1'b0;
        end
    end

    always_comb begin
        full = (count_q == CW'(FIFO_DEPTH));
        pop  = valid_q & Out_Ready;
        push = Done & (~full | pop);
        drop = Done & full & ~pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
        end

        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        valid_d = (count_d != '0);

        // Head is taken from the post-write array so an entry written into an
        // otherwise-empty FIFO is visible right after the same edge.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (Clr_Ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Out_Valid = valid_q;
    assign Cociente  = head_q.coc;
    assign Resto     = head_q.res;
    assign DivZero   = head_q.dz;
    assign Overflow  = ovf_q;
    assign Count     = count_q;

endmodule

// File: tb/tb_div_result_stage.sv
// Self-checking bench for div_result_stage: queue-based reference model compared
// every cycle, plus directed literal checks of the sign, zero and FIFO corner cases.
module tb_div_result_stage;

    localparam int W = 8;
    localparam int D = 4;

    logic         CLK, RSTa, Done, SignNum, SignDen, Out_Ready, Clr_Ovf;
    logic [W-1:0] Q, ACCU, M;
    logic         Out_Valid, DivZero, Overflow;
    logic [W-1:0] Cociente, Resto;
    logic [2:0]   Count;

    int errors = 0;
    int checks = 0;

    div_result_stage #(.tamanyo(W), .FIFO_DEPTH(D)) dut (
        .CLK(CLK), .RSTa(RSTa), .Done(Done), .Q(Q), .ACCU(ACCU), .M(M),
        .SignNum(SignNum), .SignDen(SignDen), .Out_Ready(Out_Ready), .Clr_Ovf(Clr_Ovf),
        .Out_Valid(Out_Valid), .Cociente(Cociente), .Resto(Resto), .DivZero(DivZero),
        .Overflow(Overflow), .Count(Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of signed results.
    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] r;
        logic         z;
    } res_t;

    res_t         mq[$];
    logic         m_ovf;
    logic [W-1:0] m_c, m_r;
    logic         m_z;

    always @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            mq.delete();
            m_ovf = 1'b0;
            m_c = '0; m_r = '0; m_z = 1'b0;
        end else begin
            res_t e;
            bit   p, f, dropped;
            p = (mq.size() != 0) && Out_Ready;
            f = (mq.size() == D);
            dropped = 1'b0;
            if (M == 0) begin
                e.c = 8'hFF; e.r = 8'h00; e.z = 1'b1;
            end else begin
                e.c = (SignNum != SignDen) ? W'(0 - Q) : Q;
                e.r = SignNum ? W'(0 - ACCU) : ACCU;
                e.z = 1'b0;
            end
            if (p) void'(mq.pop_front());
            if (Done) begin
                if (!f || p) mq.push_back(e);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (Clr_Ovf) m_ovf = 1'b0;
            if (mq.size() != 0) begin
                m_c = mq[0].c; m_r = mq[0].r; m_z = mq[0].z;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RSTa) begin
            check("m_valid", 32'(Out_Valid), 32'(mq.size() != 0));
            check("m_count", 32'(Count), 32'(mq.size()));
            check("m_ovf", 32'(Overflow), 32'(m_ovf));
            check("m_coc", 32'(Cociente), 32'(m_c));
            check("m_res", 32'(Resto), 32'(m_r));
            check("m_dz", 32'(DivZero), 32'(m_z));
        end
    end

    task automatic step(input logic d, input logic [W-1:0] q, input logic [W-1:0] a,
                        input logic [W-1:0] m, input logic sn, input logic sd,
                        input logic rdy, input logic clr);
        Done = d; Q = q; ACCU = a; M = m; SignNum = sn; SignDen = sd;
        Out_Ready = rdy; Clr_Ovf = clr;
        @(posedge CLK); #1;
        Done = 1'b0; Clr_Ovf = 1'b0;
    endtask

    initial begin
        RSTa = 1'b1; Done = 0; Q = 0; ACCU = 0; M = 0; SignNum = 0; SignDen = 0;
        Out_Ready = 0; Clr_Ovf = 0;
        #3;
        check("rst_valid", 32'(Out_Valid), 0);
        check("rst_count", 32'(Count), 0);
        check("rst_coc", 32'(Cociente), 0);
        check("rst_ovf", 32'(Overflow), 0);
        #9 RSTa = 1'b0;

        // -7/2
        step(1, 3, 1, 2, 1, 0, 0, 0);
        check("n7d2_valid", 32'(Out_Valid), 1);
        check("n7d2_coc", 32'(Cociente), 32'h FD);
        check("n7d2_res", 32'(Resto), 32'h FF);
        check("n7d2_dz", 32'(DivZero), 0);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        // 7/-2 into empty FIFO with Out_Ready high: no pop, lands
        step(1, 3, 1, 2, 0, 1, 1, 0);
        check("7nd2_coc", 32'(Cociente), 32'h FD);
        check("7nd2_res", 32'(Resto), 32'h 01);
        check("7nd2_count", 32'(Count), 1);
        // -7/-2 while popping previous
        step(1, 3, 1, 2, 1, 1, 1, 0);
        check("n7nd2_coc", 32'(Cociente), 32'h 03);
        check("n7nd2_res", 32'(Resto), 32'h FF);
        check("n7nd2_count", 32'(Count), 1);
        // divide by zero
        step(1, 3, 5, 0, 1, 0, 1, 0);
        check("dz_coc", 32'(Cociente), 32'h FF);
        check("dz_res", 32'(Resto), 32'h 00);
        check("dz_flag", 32'(DivZero), 1);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        check("hold_valid", 32'(Out_Valid), 0);
        check("hold_coc", 32'(Cociente), 32'h FF);
        check("hold_dz", 32'(DivZero), 1);

        // Overflow: five pushes into depth 4
        for (int i = 1; i <= 5; i++) step(1, W'(i), 0, 1, 0, 0, 0, 0);
        check("ovf_count", 32'(Count), 4);
        check("ovf_flag", 32'(Overflow), 1);
        check("ovf_head", 32'(Cociente), 1);
        for (int i = 2; i <= 4; i++) begin
            step(0, 0, 0, 1, 0, 0, 1, 0);
            check("drain_coc", 32'(Cociente), 32'(i));
        end
        step(0, 0, 0, 1, 0, 0, 1, 0);
        check("drain_valid", 32'(Out_Valid), 0);
        check("drain_ovf", 32'(Overflow), 1);
        step(0, 0, 0, 1, 0, 0, 0, 1);
        check("clr_ovf", 32'(Overflow), 0);

        // Full with simultaneous push and pop
        for (int i = 5; i <= 8; i++) step(1, W'(i), 0, 1, 0, 0, 0, 0);
        step(1, 9, 0, 1, 0, 0, 1, 0);
        check("fullpp_count", 32'(Count), 4);
        check("fullpp_ovf", 32'(Overflow), 0);
        for (int i = 6; i <= 9; i++) begin
            check("fullpp_order", 32'(Cociente), 32'(i));
            step(0, 0, 0, 1, 0, 0, 1, 0);
        end
        check("fullpp_empty", 32'(Out_Valid), 0);

        // Asynchronous reset with entries held
        for (int i = 1; i <= 3; i++) step(1, W'(i), 0, 1, 0, 0, 0, 0);
        Out_Ready = 1'b1;
        #1 RSTa = 1'b1;
        #1;
        check("arst_valid", 32'(Out_Valid), 0);
        check("arst_count", 32'(Count), 0);
        check("arst_ovf", 32'(Overflow), 0);
        #1 RSTa = 1'b0;
        step(1, 7, 0, 1, 0, 0, 0, 0);
        check("arst_after", 32'(Count), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] rq, ra, rm;
            rq = ($urandom_range(0, 9) == 0) ? 8'h80 : W'($urandom);
            ra = W'($urandom);
            rm = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            step(1'($urandom_range(0, 9) < 6), rq, ra, rm, 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_result_stage.md
Name: div_result_stage

Overview:
Output stage of the pipelined signed binary divider; sits directly downstream of the last iteration stage. It samples the unsigned quotient and remainder magnitudes, applies sign correction, and flags divide-by-zero. Results go into a small in-order FIFO with a valid/ready handshake, because the iteration pipeline has no stall. Overflow of that FIFO is reported through a sticky flag.

Parameters:
tamanyo, 32, data width of quotient, remainder and divisor (≥2)
FIFO_DEPTH, 4, result buffer entries (power of two, ≥2)

Ports:
CLK  input  1  clock, rising edge
RSTa  input  1  asynchronous reset, active-high
Done  input  1  last pipeline stage holds a valid result this cycle
Q  input  tamanyo  quotient magnitude
ACCU  input  tamanyo  remainder magnitude
M  input  tamanyo  divisor magnitude
SignNum  input  1  numerator sign (1 = negative)
SignDen  input  1  denominator sign (1 = negative)
Out_Ready  input  1  consumer accepts head entry
Clr_Ovf  input  1  synchronous clear of Overflow
Out_Valid  output  1  head entry valid
Cociente  output  tamanyo  signed quotient, two's complement
Resto  output  tamanyo  signed remainder, two's complement
DivZero  output  1  head entry came from M == 0
Overflow  output  1  sticky: a result was dropped
Count  output  $clog2(FIFO_DEPTH)+1  entries currently held

Behaviour:
- Reset: RSTa=1 clears everything asynchronously, including during an active transfer. Out_Valid=0, Cociente=0, Resto=0, DivZero=0, Overflow=0, Count=0. Pointers go to 0 and FIFO contents are discarded.
- Sign correction (combinational, before write):
  - neg_q = SignNum ^ SignDen.
  - Cociente = neg_q ? (~Q + 1) : Q.
  - Resto = SignNum ? (~ACCU + 1) : ACCU. The remainder takes the sign of the numerator.
  - Arithmetic is modulo 2^tamanyo and no saturation is applied. A magnitude of 2^(tamanyo-1) negated yields the same bit pattern.
- Divide-by-zero: if M == 0 when Done=1, the entry is stored with Cociente = all ones, Resto = 0 and DivZero = 1. Sign inputs are ignored for that entry.
- Write: on the rising edge where Done=1, one entry {Cociente, Resto, DivZero} is pushed. Inputs are sampled that same edge.
- Read: a pop happens on the rising edge where Out_Valid=1 and Out_Ready=1. The head advances and the next entry appears after the edge.
- Outputs:
  - Cociente, Resto and DivZero always show the head entry. They hold their last value while empty.
  - Out_Valid = (Count != 0), driven from registered state.
  - Latency: Done sampled at edge N, into an empty FIFO, gives Out_Valid=1 with that data after edge N.
- Ordering: strictly in the order of Done pulses.
- Full and empty cases:
  - Full with Done=1 and a pop in the same cycle: the write is accepted and Count is unchanged.
  - Full with Done=1 and no pop: the entry is dropped and Overflow is set after that edge. Stored entries are untouched.
  - Empty with Done=1 and Out_Ready=1: no pop occurs, since Out_Valid=0. The write lands and Count becomes 1.
  - Out_Ready=1 while empty has no effect.
- Overflow:
  - Stays set until Clr_Ovf=1 at a clock edge or reset.
  - If Clr_Ovf=1 and a new drop happen in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. Count runs from 0 to FIFO_DEPTH.

Test Plan:
- tamanyo=8, Done=1 with Q=3, ACCU=1, M=2, SignNum=1, SignDen=0 (−7/2) -> next cycle Out_Valid=1, Cociente=8'hFD, Resto=8'hFF, DivZero=0.
- Q=3, ACCU=1, M=2, SignNum=0, SignDen=1 (7/−2) -> Cociente=8'hFD, Resto=8'h01. With both signs 1 (−7/−2) -> Cociente=8'h03, Resto=8'hFF.
- M=0 with Done=1, SignNum=1 -> Cociente=8'hFF, Resto=8'h00, DivZero=1.
- FIFO_DEPTH=4, Out_Ready=0, five Done pulses with Q=1..5 -> Count=4, Overflow=1, Q=5 dropped. Then Out_Ready=1 drains Cociente 1,2,3,4 on consecutive cycles, Out_Valid falls after the 4th. Overflow stays 1 until a Clr_Ovf pulse.
- FIFO full, Done=1 with Q=9 and Out_Ready=1 in the same cycle -> Count stays 4, Overflow stays 0, Q=9 emerges last.
- Reset asserted with 3 entries held and Out_Ready=1 -> Out_Valid=0, Count=0, Overflow=0 immediately without a clock edge. A Done pulse after release gives Count=1.
